// File: rtl/dm_sram_responder.sv
// dm_sram_responder: word-addressed data SRAM with byte-lane writes, registered read and post-reset clear.
// Optional per-lane even parity with sticky error capture when DM_PARITY_EN is defined.
module dm_sram_responder #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cs,
    input  logic                oe,
    input  logic [DATA_W/8-1:0] web,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   di,
    output logic [DATA_W-1:0]   do_o,
    output logic                busy,
    output logic                par_err,
    output logic [ADDR_W-1:0]   err_addr
);
    localparam int LANES = DATA_W / 8;
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] SERVE = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic              rd;

    assign rd   = (state == SERVE) && cs && oe;
    assign do_o = oe ? rd_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            rd_q    <= '0;
            busy    <= 1'b1;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            state   <= (&clr_cnt) ? SERVE : CLEAR;
            busy    <= ~(&clr_cnt);
        end else if (rd) begin
            rd_q <= mem[addr];
        end
    end

    // Memory has no reset of its own; the CLEAR sweep is what initialises it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR)
                mem[clr_cnt] <= INIT_VAL;
            else if (cs)
                for (int i = 0; i < LANES; i++)
                    if (!web[i]) mem[addr][8*i +: 8] <= di[8*i +: 8];
        end
    end

`ifdef DM_PARITY_EN
    logic [LANES-1:0]  par [2**ADDR_W];
    logic              pe_q;
    logic [ADDR_W-1:0] pa_q;

    function automatic logic [LANES-1:0] lane_par(input logic [DATA_W-1:0] d);
        for (int i = 0; i < LANES; i++) lane_par[i] = ^d[8*i +: 8];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR)
                par[clr_cnt] <= lane_par(INIT_VAL);
            else if (cs)
                for (int i = 0; i < LANES; i++)
                    if (!web[i]) par[addr][i] <= ^di[8*i +: 8];
        end
    end

    // Check happens on the read edge; the sticky flag updates one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            pe_q     <= 1'b0;
            pa_q     <= '0;
            par_err  <= 1'b0;
            err_addr <= '0;
        end else begin
            pe_q <= rd && (lane_par(mem[addr]) != par[addr]);
            pa_q <= addr;
            if (pe_q) begin
                par_err  <= 1'b1;
                err_addr <= par_err ? err_addr : pa_q;
            end
        end
    end
`else
    assign par_err  = 1'b0;
    assign err_addr = '0;
`endif
endmodule

// File: tb/tb_dm_sram_responder.sv
// tb_dm_sram_responder: randomized scoreboard bench for dm_sram_responder with a word-array reference model.
module tb_dm_sram_responder;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int DEPTH = 16;

    logic          clk = 0;
    logic          rst = 1;
    logic          cs = 0;
    logic          oe = 0;
    logic [3:0]    web = 4'hf;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] di = '0;
    logic [DW-1:0] do_o;
    logic          busy;
    logic          par_err;
    logic [AW-1:0] err_addr;

    dm_sram_responder #(.ADDR_W(AW), .DATA_W(DW), .INIT_VAL('0)) dut (
        .clk(clk), .rst(rst), .cs(cs), .oe(oe), .web(web), .addr(addr), .di(di),
        .do_o(do_o), .busy(busy), .par_err(par_err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic          in_clear = 1;
    logic [DW-1:0] last = '0;
    logic          s_rst, s_rd, s_clear;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: a read sampled at an edge retires the oldest expected word.
    always @(posedge clk) begin
        s_rst   = rst;
        s_rd    = cs && oe && !in_clear;
        s_clear = in_clear;
        #1;
        if (s_rst) last = '0;
        else if (s_rd) begin
            if (exp_q.size() == 0) check("underflow", 1, 0);
            else last = exp_q.pop_front();
        end
        check("do_o", do_o, oe ? last : '0);
        if (!s_clear && !s_rst) check("busy_serve", {31'b0, busy}, 0);
`ifndef DM_PARITY_EN
        check("par_tied", {27'b0, par_err, err_addr}, 0);
`endif
    end

    // Drive one cycle at a negedge and update the reference model for the coming edge.
    task automatic drive(input logic c, input logic o, input logic [3:0] w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        cs = c; oe = o; web = w; addr = a; di = d;
        if (!in_clear && !rst && c) begin
            if (o) exp_q.push_back(ref_mem[a]);
            for (int i = 0; i < 4; i++)
                if (!w[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
        end
        @(negedge clk);
    endtask

    task automatic junk();
        drive(1'($urandom), 1'($urandom), 4'($urandom), AW'($urandom), $urandom);
    endtask

    // Reset with a write in flight; abort>0 re-asserts reset after that many clear cycles.
    task automatic do_reset(input int abort);
        int n;
        rst = 1; in_clear = 1;
        cs = 1; oe = 1; web = 4'h0; addr = 2; di = 32'h55;
        @(negedge clk);
        rst = 0;
        n = 0;
        while (busy && n < 40 && !(abort > 0 && n == abort)) begin
            n++;
            junk();
        end
        if (abort == 0) begin
            check("busy_cycles", n, DEPTH);
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            in_clear = 0;
            cs = 0; oe = 0; web = 4'hf;
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) drive(1, 1, 4'hf, AW'(i), $urandom);
        drive(0, 1, 4'hf, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        @(negedge clk);
        do_reset(0);
        read_all();
        drive(1, 0, 4'h0, 3, 32'hDEADBEEF);
        drive(1, 1, 4'hf, 3, 0);
        drive(0, 1, 4'hf, 0, 0);
        drive(0, 0, 4'hf, 0, 0);
        drive(1, 0, 4'h0, 4, 32'hAABBCCDD);
        drive(1, 0, 4'hc, 4, 32'h11223344);
        drive(1, 1, 4'hf, 4, 0);
        drive(1, 0, 4'h0, 5, 32'h1);
        drive(1, 1, 4'h0, 5, 32'h2);
        drive(1, 1, 4'hf, 5, 0);
        drive(1, 1, 4'hf, 5, 0);
        drive(1, 0, 4'hf, 6, 32'hFFFF0000);
        drive(0, 1, 4'h0, 6, 32'h12345678);
        drive(1, 1, 4'hf, 6, 0);
        do_reset(5);
        do_reset(0);
        drive(1, 0, 4'h0, 2, 32'h55);
        drive(1, 1, 4'hf, 2, 0);
        do_reset(0);
        drive(1, 1, 4'hf, 2, 0);
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 9) < 8), 1'($urandom), 4'($urandom), AW'($urandom), $urandom);
            if (k == 200) do_reset(0);
        end
        read_all();
`ifdef DM_PARITY_EN
        check("par_clean", {31'b0, par_err}, 0);
        drive(1, 0, 4'h0, 7, $urandom);
        drive(1, 0, 4'h0, 9, $urandom);
        dut.mem[7][0] = ~dut.mem[7][0];
        ref_mem[7][0] = ~ref_mem[7][0];
        drive(1, 1, 4'hf, 7, 0);
        drive(0, 1, 4'hf, 0, 0);
        drive(0, 1, 4'hf, 0, 0);
        check("par_err_first", {31'b0, par_err}, 1);
        check("err_addr_first", {28'b0, err_addr}, 7);
        dut.mem[9][12] = ~dut.mem[9][12];
        ref_mem[9][12] = ~ref_mem[9][12];
        drive(1, 1, 4'hf, 9, 0);
        drive(0, 1, 4'hf, 0, 0);
        drive(0, 1, 4'hf, 0, 0);
        check("par_err_sticky", {31'b0, par_err}, 1);
        check("err_addr_kept", {28'b0, err_addr}, 7);
`endif
        drive(0, 0, 4'hf, 0, 0);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
